// File: rtl/kennedy_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Bit periods are counted in s_tick strobes from the shared baud generator.
module kennedy_transmitter #(
  parameter int OVERSAMPLE_RATE = 16,
  parameter int PARITY_EN       = 0,
  parameter int PARITY_ODD      = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       tx_enabled,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       s_tick,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE_RATE - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_tick, w_tick_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_par, w_par_nxt;
  logic        r_stop, w_stop_nxt;
  logic        w_tx_nxt, w_busy_nxt, w_done_nxt;
  logic        w_bit_end;

  assign w_bit_end = s_tick && (r_tick == LAST_TICK);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_stop  <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_stop  <= w_stop_nxt;
      tx      <= w_tx_nxt;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_stop_nxt  = r_stop;
    w_done_nxt  = 1'b0;
    // Non-bit-end ticks just advance the counter; idle cycles hold everything.
    if (s_tick && !w_bit_end) w_tick_nxt = r_tick + 4'd1;
    case (r_state)
      IDLE: begin
        w_tick_nxt = r_tick;
        if (start && tx_enabled) begin
          w_shift_nxt = data_in;
          w_par_nxt   = (^data_in) ^ (PARITY_ODD != 0);
          w_tick_nxt  = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_tick_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_tick_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_stop_nxt  = 1'b0;
            w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_tick_nxt  = '0;
          w_stop_nxt  = 1'b0;
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_tick_nxt = '0;
          if (STOP_BITS == 2 && !r_stop) begin
            w_stop_nxt = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tick_nxt  = '0;
      end
    endcase
    // Line level follows the state being entered so tx comes straight from a flop.
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      PARITY:  w_tx_nxt = r_par;
      default: w_tx_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

endmodule

// File: doc/kennedy_transmitter.md
Name: kennedy_transmitter

Overview:
- UART serial transmitter; pairs with the team's oversampled UART receiver to give full-duplex TX/RX.
- Accepts one parallel byte per handshake and serialises it on `tx`: start bit, 8 data bits LSB-first, optional parity bit, 1 or 2 stop bits.
- Bit timing is derived from the shared baud-rate generator's `s_tick` strobe.
- One bit period is OVERSAMPLE_RATE ticks, the same tick count the receiver uses.

Parameters:
- OVERSAMPLE_RATE, 16: s_tick strobes per bit period; legal values 2..16 (4-bit tick counter).
- PARITY_EN, 0: 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock.
- rstN  input  1  asynchronous active-low reset.
- tx_enabled  input  1  gates acceptance of new frames only.
- start  input  1  request to send data_in; sampled every clk.
- data_in  input  8  byte to send; captured on the accept cycle.
- s_tick  input  1  one-clk oversample strobe from the baud generator.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress; new starts are ignored while high.
- done  output  1  one-clk pulse at end of frame.

Behaviour:
- Interface decision: one clock (`clk`); reset `rstN` is asynchronous and active-low.
- Reset values: state=IDLE, tx=1, busy=0, done=0, tick counter=0, bit counter=0, shift register=0.
- All outputs are registered. `tx` is driven from a flop and must not glitch.

State machine (IDLE, START, DATA, PARITY, STOP):
- IDLE:
  - tx=1.
  - Accept condition: start && tx_enabled && state==IDLE.
  - On accept: latch data_in into the shift register, compute the parity bit (XOR of data_in, inverted if PARITY_ODD), clear the tick counter, go to START.
  - On the next clk edge: busy=1 and tx=0.
- START:
  - tx=0.
  - Tick counter increments on each s_tick.
  - On the s_tick that arrives with counter==OVERSAMPLE_RATE-1: clear the counter, clear the bit counter, go to DATA.
- DATA:
  - tx = shift register bit 0.
  - At each bit-end tick (counter==OVERSAMPLE_RATE-1 with s_tick): shift right and increment the 3-bit bit counter.
  - After bit 7 (bit counter==7 at bit-end): go to PARITY if PARITY_EN, else go to STOP.
- PARITY:
  - tx = parity bit for one bit period, then go to STOP.
- STOP:
  - tx=1 for STOP_BITS*OVERSAMPLE_RATE ticks; a stop-bit sub-counter is allowed.
  - At the final tick: go to IDLE.
  - On that edge: busy=0 and done=1 for exactly one clk.

Timing rules:
- Ticks where s_tick=0 hold all counters. Bit periods are measured purely in s_tick counts.
- Frame length: (10 + PARITY_EN + STOP_BITS - 1) * OVERSAMPLE_RATE ticks from START entry to IDLE return.
- Latency: tx falls one clk after the accept cycle, independent of s_tick phase. The start bit therefore lasts OVERSAMPLE_RATE ticks plus partial-tick jitter of up to one tick period.

Boundary conditions:
- start while busy=1: ignored, with no queuing.
- start in the same cycle done=1: accepted, because state is IDLE on that cycle. Back-to-back frames then have no gap beyond the stop bits.
- tx_enabled falling mid-frame: the current frame completes normally. Only new accepts are blocked.
- data_in changing after accept: no effect on the current frame.
- start and s_tick on the same cycle in IDLE: the tick is not counted. Counting begins with the first s_tick after START entry.
- rstN asserted mid-frame: immediate return to the reset values (tx=1 asynchronously). No done pulse is generated.
- Illegal or unused state encodings: recover to IDLE with tx=1.

Test Plan:
1. Defaults, s_tick every 4 clks; start with data_in=8'hA5 → tx sequence 0, 1,0,1,0,0,1,0,1, 1, each bit exactly 16 ticks (64 clks). busy high for the whole frame. One done pulse. The team's receiver looped back reports out=8'hA5 and done.
2. PARITY_EN=1, PARITY_ODD=0, data_in=8'h07 → parity bit=1. With PARITY_ODD=1 → parity bit=0. Frame is 11 bits (176 ticks).
3. STOP_BITS=2, data_in=8'h00 → tx high for 32 ticks after data. done asserts 32 ticks after the last data bit ends.
4. Hold start=1 continuously with data_in=8'h55 then 8'hAA → second start bit begins the clk after done. No idle gap. Both bytes are correct.
5. Pulse start mid-frame, and drop tx_enabled mid-frame → no second frame. The current frame completes intact. start with tx_enabled=0 in IDLE → tx stays 1 and busy stays 0.
6. Assert rstN low during DATA bit 3 → tx=1, busy=0, done=0 immediately. After release, a fresh start of 8'h3C transmits correctly.
